// File: rtl/cpu_seq_pkg.sv
// cpu_seq_pkg: sequencer states and bus constants shared by the Avalon CPU sequencer.
package cpu_seq_pkg;

    typedef enum logic [2:0] {FETCH, EXEC, MEM, WB, STALL, HALT} seq_state_t;

    localparam logic [3:0]  BYTEEN_WORD = 4'hF;
    localparam logic [31:0] WORD_MASK   = 32'hFFFF_FFFC;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return a & WORD_MASK;
    endfunction

endpackage

// File: rtl/avalon_wait_timer.sv
// avalon_wait_timer: counts consecutive waitrequest cycles of one bus access and flags a timeout.
module avalon_wait_timer #(
    parameter int TIMEOUT   = 0,
    parameter int TIMEOUT_W = 8
) (
    input  logic i_clk,
    input  logic i_reset_n,
    input  logic i_busy,
    input  logic i_wait,
    output logic o_timeout
);

    logic [TIMEOUT_W-1:0] r_cnt;

    // The cycle that would make the count reach TIMEOUT is itself the timeout cycle.
    assign o_timeout = (TIMEOUT != 0) && i_busy && i_wait && (r_cnt == TIMEOUT_W'(TIMEOUT - 1));

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            r_cnt <= '0;
        else
            r_cnt <= (i_busy && i_wait) ? r_cnt + 1'b1 : '0;
    end

endmodule

// File: rtl/avalon_cpu_sequencer.sv
// avalon_cpu_sequencer: multi-cycle FETCH/EXEC/MEM/WB/STALL sequencer owning the core's
// Avalon-MM master port and generating the exec/writeback/PC strobes.
module avalon_cpu_sequencer
    import cpu_seq_pkg::*;
#(
    parameter logic [31:0] HALT_PC   = 32'h0000_0000,
    parameter int          TIMEOUT   = 0,
    parameter int          TIMEOUT_W = 8
) (
    input  logic        i_clk,
    input  logic        i_reset_n,
    input  logic [31:0] i_pc,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    input  logic [31:0] i_mem_addr,
    input  logic [31:0] i_mem_wdata,
    input  logic [3:0]  i_mem_byteen,
    input  logic        i_multdiv_busy,
    output logic [31:0] o_avm_address,
    output logic        o_avm_read,
    output logic        o_avm_write,
    output logic [31:0] o_avm_writedata,
    output logic [3:0]  o_avm_byteenable,
    input  logic [31:0] i_avm_readdata,
    input  logic        i_avm_waitrequest,
    output logic [31:0] o_instr,
    output logic [31:0] o_mem_rdata,
    output logic        o_exec_en,
    output logic        o_wb_en,
    output logic        o_pc_en,
    output logic        o_active,
    output logic        o_err
);

    seq_state_t  r_state;
    logic        r_go;
    logic        r_mem_rd;
    logic        r_mem_wr;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_be;
    logic [31:0] r_instr;
    logic [31:0] r_mem_rdata;
    logic        r_err;

    logic w_fetch;
    logic w_mem;
    logic w_exec;
    logic w_both;
    logic w_commit;
    logic w_timeout;

    // r_go holds off the first fetch until one clock after reset so the bus stays idle in reset.
    assign w_fetch  = (r_state == FETCH) && r_go && (i_pc != HALT_PC);
    assign w_mem    = (r_state == MEM);
    assign w_exec   = (r_state == EXEC);
    assign w_both   = i_mem_read && i_mem_write;
    assign w_commit = (w_exec && !i_mem_read && !i_mem_write && !i_multdiv_busy)
                   || (r_state == WB)
                   || (r_state == STALL && !i_multdiv_busy);

    assign o_avm_read       = w_fetch || (w_mem && r_mem_rd);
    assign o_avm_write      = w_mem && r_mem_wr;
    assign o_avm_address    = w_mem ? r_addr : w_fetch ? word_align(i_pc) : '0;
    assign o_avm_byteenable = w_mem ? r_be : w_fetch ? BYTEEN_WORD : 4'h0;
    assign o_avm_writedata  = w_mem ? r_wdata : '0;

    assign o_exec_en   = w_exec && !w_both;
    assign o_wb_en     = w_commit;
    assign o_pc_en     = w_commit;
    assign o_active    = (r_state != HALT);
    assign o_err       = r_err;
    assign o_instr     = r_instr;
    assign o_mem_rdata = r_mem_rdata;

    avalon_wait_timer #(
        .TIMEOUT   (TIMEOUT),
        .TIMEOUT_W (TIMEOUT_W)
    ) u_timer (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_busy    (o_avm_read || o_avm_write),
        .i_wait    (i_avm_waitrequest),
        .o_timeout (w_timeout)
    );

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state     <= FETCH;
            r_go        <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_be        <= 4'h0;
            r_instr     <= '0;
            r_mem_rdata <= '0;
            r_err       <= 1'b0;
        end else begin
            r_go <= 1'b1;
            case (r_state)
                FETCH: begin
                    if (r_go && i_pc == HALT_PC) begin
                        r_state <= HALT;
                    end else if (w_fetch && w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= HALT;
                    end else if (w_fetch && !i_avm_waitrequest) begin
                        r_instr <= i_avm_readdata;
                        r_state <= EXEC;
                    end
                end
                EXEC: begin
                    // The access is captured here so it stays stable for the whole MEM phase.
                    r_mem_rd <= i_mem_read;
                    r_mem_wr <= i_mem_write;
                    r_addr   <= word_align(i_mem_addr);
                    r_be     <= i_mem_byteen;
                    r_wdata  <= i_mem_wdata;
                    if (w_both) begin
                        r_err   <= 1'b1;
                        r_state <= HALT;
                    end else if (i_mem_read || i_mem_write) begin
                        r_state <= MEM;
                    end else if (i_multdiv_busy) begin
                        r_state <= STALL;
                    end else begin
                        r_state <= FETCH;
                    end
                end
                MEM: begin
                    if (w_timeout) begin
                        r_err   <= 1'b1;
                        r_state <= HALT;
                    end else if (!i_avm_waitrequest) begin
                        if (r_mem_rd)
                            r_mem_rdata <= i_avm_readdata;
                        r_state <= WB;
                    end
                end
                WB:      r_state <= FETCH;
                STALL:   r_state <= i_multdiv_busy ? STALL : FETCH;
                default: r_state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_avalon_cpu_sequencer.sv
// tb_avalon_cpu_sequencer: expands instruction descriptors into per-cycle stimulus/expectation
// records, applies them in a loop, and adds hand-written reset and timeout sequences.
module tb_avalon_cpu_sequencer;

    localparam logic [31:0] HALT = 32'h0000_0000;
    localparam int          TMO  = 4;

    typedef enum int {K_ALU, K_LD, K_ST, K_MUL, K_BAD} kind_t;

    typedef struct {
        logic [31:0] pc;
        logic        mr;
        logic        mw;
        logic [31:0] maddr;
        logic [31:0] wdata;
        logic [3:0]  be;
        logic        busy;
        logic [31:0] rdata;
        logic        wt;
        logic        e_rd;
        logic        e_wr;
        logic [31:0] e_addr;
        logic [3:0]  e_be;
        logic [31:0] e_wdata;
        logic        e_ex;
        logic        e_wb;
        logic        e_pc;
        logic        e_act;
        logic        e_err;
        logic [31:0] e_instr;
        logic [31:0] e_mrd;
    } cyc_t;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] pc = '0;
    logic        mem_read = 1'b0;
    logic        mem_write = 1'b0;
    logic [31:0] mem_addr = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  mem_byteen = '0;
    logic        multdiv_busy = 1'b0;
    logic [31:0] avm_address;
    logic        avm_read;
    logic        avm_write;
    logic [31:0] avm_writedata;
    logic [3:0]  avm_byteenable;
    logic [31:0] avm_readdata = '0;
    logic        avm_waitrequest = 1'b0;
    logic [31:0] instr;
    logic [31:0] mem_rdata;
    logic        exec_en;
    logic        wb_en;
    logic        pc_en;
    logic        active;
    logic        err;

    int total = 0;
    int bad = 0;

    cyc_t        tq[$];
    logic [31:0] m_pc;
    logic [31:0] m_instr;
    logic [31:0] m_mrd;
    logic        m_halt;
    logic        m_err;

    always #5 clk = ~clk;

    avalon_cpu_sequencer #(
        .HALT_PC   (HALT),
        .TIMEOUT   (TMO),
        .TIMEOUT_W (8)
    ) dut (
        .i_clk             (clk),
        .i_reset_n         (reset_n),
        .i_pc              (pc),
        .i_mem_read        (mem_read),
        .i_mem_write       (mem_write),
        .i_mem_addr        (mem_addr),
        .i_mem_wdata       (mem_wdata),
        .i_mem_byteen      (mem_byteen),
        .i_multdiv_busy    (multdiv_busy),
        .o_avm_address     (avm_address),
        .o_avm_read        (avm_read),
        .o_avm_write       (avm_write),
        .o_avm_writedata   (avm_writedata),
        .o_avm_byteenable  (avm_byteenable),
        .i_avm_readdata    (avm_readdata),
        .i_avm_waitrequest (avm_waitrequest),
        .o_instr           (instr),
        .o_mem_rdata       (mem_rdata),
        .o_exec_en         (exec_en),
        .o_wb_en           (wb_en),
        .o_pc_en           (pc_en),
        .o_active          (active),
        .o_err             (err)
    );

    task automatic check(input string name, input logic [95:0] got, input logic [95:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    // A cycle with no bus activity or strobes; inputs the sequencer must ignore are randomized.
    function automatic cyc_t blank();
        cyc_t c;
        c.pc      = m_pc;
        c.mr      = 1'($urandom);
        c.mw      = 1'($urandom);
        c.maddr   = $urandom;
        c.wdata   = $urandom;
        c.be      = 4'($urandom);
        c.busy    = 1'($urandom);
        c.rdata   = $urandom;
        c.wt      = 1'($urandom);
        c.e_rd    = 1'b0;
        c.e_wr    = 1'b0;
        c.e_addr  = '0;
        c.e_be    = '0;
        c.e_wdata = '0;
        c.e_ex    = 1'b0;
        c.e_wb    = 1'b0;
        c.e_pc    = 1'b0;
        c.e_act   = !m_halt;
        c.e_err   = m_err;
        c.e_instr = m_instr;
        c.e_mrd   = m_mrd;
        return c;
    endfunction

    task automatic add_idle();
        tq.push_back(blank());
    endtask

    task automatic add_halted(input int n);
        for (int i = 0; i < n; i++) tq.push_back(blank());
    endtask

    task automatic add_fetch(input int fw, input logic [31:0] word);
        cyc_t c;
        for (int i = 0; i <= fw; i++) begin
            c = blank();
            c.wt = (i < fw);
            if (i == fw) c.rdata = word;
            c.e_rd   = 1'b1;
            c.e_addr = m_pc & 32'hFFFF_FFFC;
            c.e_be   = 4'hF;
            tq.push_back(c);
        end
        m_instr = word;
    endtask

    task automatic add_instr(input kind_t k, input int fw, input int mwt, input int st,
                             input logic [31:0] word, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be,
                             input logic [31:0] rdata);
        cyc_t c;
        int   n;
        add_fetch(fw, word);
        c = blank();
        c.mr = (k == K_LD || k == K_BAD);
        c.mw = (k == K_ST || k == K_BAD);
        c.maddr = addr;
        c.wdata = wdata;
        c.be = be;
        if (k == K_ALU) c.busy = 1'b0;
        if (k == K_MUL) c.busy = 1'b1;
        c.e_ex = (k != K_BAD);
        c.e_wb = (k == K_ALU);
        c.e_pc = (k == K_ALU);
        tq.push_back(c);
        if (k == K_BAD) begin
            m_halt = 1'b1;
            m_err  = 1'b1;
            return;
        end
        if (k == K_MUL) begin
            for (int i = 0; i < st; i++) begin
                c = blank();
                c.busy = 1'b1;
                tq.push_back(c);
            end
            c = blank();
            c.busy = 1'b0;
            c.e_wb = 1'b1;
            c.e_pc = 1'b1;
            tq.push_back(c);
        end
        if (k == K_LD || k == K_ST) begin
            n = (mwt >= TMO) ? TMO - 1 : mwt;
            for (int i = 0; i <= n; i++) begin
                c = blank();
                c.mr = (k == K_LD);
                c.mw = (k == K_ST);
                c.maddr = addr;
                c.wdata = wdata;
                c.be = be;
                c.wt = (i < mwt);
                if (i == mwt) c.rdata = rdata;
                c.e_rd    = (k == K_LD);
                c.e_wr    = (k == K_ST);
                c.e_addr  = addr & 32'hFFFF_FFFC;
                c.e_be    = be;
                c.e_wdata = wdata;
                tq.push_back(c);
            end
            if (mwt >= TMO) begin
                m_halt = 1'b1;
                m_err  = 1'b1;
                return;
            end
            if (k == K_LD) m_mrd = rdata;
            c = blank();
            c.e_wb = 1'b1;
            c.e_pc = 1'b1;
            tq.push_back(c);
        end
        m_pc += 32'd4;
    endtask

    task automatic add_halt_pc();
        m_pc = HALT;
        tq.push_back(blank());
        m_halt = 1'b1;
        add_halted(3);
    endtask

    task automatic add_fetch_timeout();
        cyc_t c;
        for (int i = 0; i < TMO; i++) begin
            c = blank();
            c.wt     = 1'b1;
            c.e_rd   = 1'b1;
            c.e_addr = m_pc & 32'hFFFF_FFFC;
            c.e_be   = 4'hF;
            tq.push_back(c);
        end
        m_halt = 1'b1;
        m_err  = 1'b1;
        add_halted(3);
    endtask

    task automatic apply(input int idx, input cyc_t c);
        logic [95:0] gb;
        logic [95:0] eb;
        logic        acc;
        pc              = c.pc;
        mem_read        = c.mr;
        mem_write       = c.mw;
        mem_addr        = c.maddr;
        mem_wdata       = c.wdata;
        mem_byteen      = c.be;
        multdiv_busy    = c.busy;
        avm_readdata    = c.rdata;
        avm_waitrequest = c.wt;
        @(negedge clk);
        acc = c.e_rd | c.e_wr;
        gb = {26'b0, avm_read, avm_write, acc ? avm_address : 32'h0,
              acc ? avm_byteenable : 4'h0, c.e_wr ? avm_writedata : 32'h0};
        eb = {26'b0, c.e_rd, c.e_wr, c.e_addr, c.e_be, c.e_wr ? c.e_wdata : 32'h0};
        check($sformatf("bus@%0d", idx), gb, eb);
        check($sformatf("strobes@%0d", idx), {91'b0, exec_en, wb_en, pc_en, active, err},
              {91'b0, c.e_ex, c.e_wb, c.e_pc, c.e_act, c.e_err});
        check($sformatf("instr@%0d", idx), {64'b0, instr}, {64'b0, c.e_instr});
        check($sformatf("mem_rdata@%0d", idx), {64'b0, mem_rdata}, {64'b0, c.e_mrd});
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n && i < tq.size(); i++) apply(i, tq[i]);
    endtask

    task automatic run_all();
        run(tq.size());
        tq.delete();
    endtask

    task automatic do_reset();
        reset_n         = 1'b0;
        pc              = 32'h0000_1230;
        mem_read        = 1'b1;
        mem_write       = 1'b0;
        multdiv_busy    = 1'b1;
        avm_waitrequest = 1'b0;
        #12;
        check("reset_bus", {58'b0, avm_read, avm_write, avm_address, avm_byteenable}, 96'h0);
        check("reset_strobes", {91'b0, exec_en, wb_en, pc_en, active, err}, 96'h2);
        check("reset_regs", {32'b0, instr, mem_rdata}, 96'h0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        m_halt  = 1'b0;
        m_err   = 1'b0;
        m_instr = '0;
        m_mrd   = '0;
        tq.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        kind_t k;
        // Directed instruction stream from the reset vector, ending in a jump to HALT_PC.
        m_pc = 32'hBFC0_0000;
        do_reset();
        add_idle();
        add_instr(K_ALU, 0, 0, 0, 32'h2408_0005, 32'h0, 32'h0, 4'h0, 32'h0);
        add_instr(K_ALU, 3, 0, 0, 32'h2529_0001, 32'h0, 32'h0, 4'h0, 32'h0);
        add_instr(K_LD, 0, 0, 0, 32'h8D09_0000, 32'h0000_1003, 32'h0, 4'hF, 32'hDEAD_BEEF);
        add_instr(K_ST, 0, 0, 0, 32'hA109_0002, 32'h0000_2002, 32'h00AB_0000, 4'b0100, 32'h0);
        add_instr(K_MUL, 0, 0, 5, 32'h0109_0018, 32'h0, 32'h0, 4'h0, 32'h0);
        add_instr(K_LD, 1, 2, 0, 32'h8D0A_0004, 32'h0000_4006, 32'h0, 4'b1100, 32'h1234_5678);
        add_instr(K_ALU, 0, 0, 0, 32'h03E0_0008, 32'h0, 32'h0, 4'h0, 32'h0);
        add_halt_pc();
        run_all();

        // Fetch stuck in waitrequest.
        m_pc = 32'h0000_0800;
        do_reset();
        add_idle();
        add_fetch_timeout();
        run_all();

        // Store stuck in waitrequest.
        m_pc = 32'h0000_0900;
        do_reset();
        add_idle();
        add_instr(K_ST, 0, 9, 0, 32'hAD09_0000, 32'h0000_5000, 32'hCAFE_F00D, 4'hF, 32'h0);
        add_halted(2);
        run_all();

        // Reset asserted while a store is waiting on the bus.
        m_pc = 32'h0000_0400;
        do_reset();
        add_idle();
        add_instr(K_ST, 0, 3, 0, 32'hAD09_0010, 32'h0000_3000, 32'h5555_AAAA, 4'b0011, 32'h0);
        run(5);
        #2;
        check("mid_mem_write_before_reset", {95'b0, avm_write}, 96'h1);
        reset_n = 1'b0;
        #1;
        check("mid_mem_reset_drop", {94'b0, avm_read, avm_write}, 96'h0);
        tq.delete();

        // Randomized instruction mix, then an illegal load+store.
        m_pc = 32'h0000_1000 | ($urandom & 32'h000F_FFFC);
        do_reset();
        add_idle();
        for (int i = 0; i < 40; i++) begin
            k = kind_t'($urandom_range(0, 3));
            add_instr(k, $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(1, 4),
                      $urandom, $urandom, $urandom, 4'($urandom), $urandom);
        end
        add_instr(K_BAD, 1, 0, 0, 32'hFFFF_0000, 32'h0000_6000, 32'h0, 4'hF, 32'h0);
        add_halted(3);
        run_all();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
